ca_hv_gen: RTL

- Sequential cellular-automaton hypervector generator for the HDC item memory.
- Loads a seed and produces a stream of successive CA generations over a valid/ready handshake.
- Generalises the fixed cyclic rule-90 step with:
  - a parametrised width;
  - a selectable rule (90 or 150);
  - a selectable boundary (cyclic or null);
  - a programmable vector count.
- Sits between the seed/config register path and the item-memory writer or encoder.

---
 rtl/ca_pkg.sv | 32 +++
 rtl/ca_step.sv | 47 ++++
 rtl/ca_hv_gen.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ca_pkg.sv
// ---------------------------------------------------------------------------
// ca_pkg
// Shared types and helpers for the cellular-automaton hypervector generator.
//   ca_rule_e  : CA update rule (90 = neighbours only, 150 = neighbours + self)
//   ca_bound_e : edge handling (cyclic wrap or zero-padded)
//   ca_state_e : generator control states
//   cnt_width  : width needed to hold a count in 0..max_cnt
// ---------------------------------------------------------------------------
package ca_pkg;

  typedef enum logic {
    RULE90  = 1'b0,
    RULE150 = 1'b1
  } ca_rule_e;

  typedef enum logic {
    BND_CYCLIC = 1'b0,
    BND_NULL   = 1'b1
  } ca_bound_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } ca_state_e;

  // Count fields must represent max_cnt itself, hence the +1.
  function automatic int cnt_width(input int max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/ca_step.sv
// ---------------------------------------------------------------------------
// ca_step
// One combinational CA generation over a DIM-bit vector.
//   vec      in  DIM  current generation
//   rule     in  1    RULE90 / RULE150
//   bound    in  1    BND_CYCLIC / BND_NULL
//   vec_next out DIM  next generation
// Bit i of the result is vec[i-1] ^ vec[i+1] (^ vec[i] for rule 150); the
// out-of-range neighbours at both ends come from the boundary mode.
// ---------------------------------------------------------------------------
module ca_step
  import ca_pkg::*;
#(
  parameter int DIM = 1024
) (
  input  logic [DIM-1:0] vec,
  input  ca_rule_e       rule,
  input  ca_bound_e      bound,
  output logic [DIM-1:0] vec_next
);

  logic wrap;
  logic self_en;

  assign wrap    = (bound == BND_CYCLIC);
  assign self_en = (rule == RULE150);

  for (genvar i = 0; i < DIM; i++) begin : g_bit
    logic left;
    logic right;

    if (i == 0) begin : g_lo_edge
      assign left = wrap & vec[DIM-1];
    end else begin : g_lo_mid
      assign left = vec[i-1];
    end

    if (i == DIM - 1) begin : g_hi_edge
      assign right = wrap & vec[0];
    end else begin : g_hi_mid
      assign right = vec[i+1];
    end

    assign vec_next[i] = left ^ right ^ (self_en & vec[i]);
  end

endmodule

// File: rtl/ca_hv_gen.sv
// ---------------------------------------------------------------------------
// ca_hv_gen
// Sequential CA hypervector generator. A command (seed, count, rule, boundary,
// include-seed flag) is accepted in IDLE; successive generations are then
// streamed out over a valid/ready handshake, one per cycle at full throughput.
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//   cmd_seed             DIM-bit seed
//   cmd_count            vectors to emit, clamped to MAX_CNT (0 = none)
//   cmd_rule/cmd_bound   CA rule and boundary mode for this command
//   cmd_incl_seed        first emitted vector is the seed itself
//   abort                synchronous cancel (RUN/FIN only, no done pulse)
//   hv_valid/hv_ready    output handshake
//   hv_data/hv_idx       current generation and its 0-based index
//   hv_last              final vector of the command
//   busy                 not in IDLE
//   done                 one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module ca_hv_gen
  import ca_pkg::*;
#(
  parameter int DIM     = 1024,
  parameter int MAX_CNT = 256,
  parameter int CNT_W   = cnt_width(MAX_CNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DIM-1:0]   cmd_seed,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_rule,
  input  logic             cmd_bound,
  input  logic             cmd_incl_seed,
  input  logic             abort,
  output logic             hv_valid,
  input  logic             hv_ready,
  output logic [DIM-1:0]   hv_data,
  output logic [CNT_W-1:0] hv_idx,
  output logic             hv_last,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_CNT);

  ca_state_e        state_q, state_d;
  logic [DIM-1:0]   data_q,  data_d;
  logic [CNT_W-1:0] idx_q,   idx_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  ca_rule_e         rule_q,  rule_d;
  ca_bound_e        bound_q, bound_d;
  logic             valid_q, valid_d;

  logic             idle;
  logic [CNT_W-1:0] cnt_clamped;
  logic [DIM-1:0]   step_in;
  logic [DIM-1:0]   step_out;
  ca_rule_e         step_rule;
  ca_bound_e        step_bound;

  assign idle        = (state_q == ST_IDLE);
  assign cnt_clamped = (cmd_count > MaxCnt) ? MaxCnt : cmd_count;

  // A single stepper serves both the seed (on acceptance, using the incoming
  // rule/boundary) and the running generation (using the latched ones).
  assign step_in    = idle ? cmd_seed             : data_q;
  assign step_rule  = idle ? ca_rule_e'(cmd_rule)  : rule_q;
  assign step_bound = idle ? ca_bound_e'(cmd_bound) : bound_q;

  ca_step #(
    .DIM (DIM)
  ) u_step (
    .vec      (step_in),
    .rule     (step_rule),
    .bound    (step_bound),
    .vec_next (step_out)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned -- otherwise synthesis infers a latch.
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rule_d  = rule_q;
    bound_d = bound_q;
    valid_d = valid_q;

    unique case (state_q)
      ST_IDLE: begin
        // abort is ignored here, so abort together with cmd_valid still accepts.
        if (cmd_valid) begin
          cnt_d   = cnt_clamped;
          rule_d  = ca_rule_e'(cmd_rule);
          bound_d = ca_bound_e'(cmd_bound);
          data_d  = cmd_incl_seed ? cmd_seed : step_out;
          idx_d   = '0;
          if (cnt_clamped == '0) begin
            state_d = ST_FIN;
            valid_d = 1'b0;
          end else begin
            state_d = ST_RUN;
            valid_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else if (valid_q && hv_ready) begin
          if (hv_last) begin
            state_d = ST_FIN;
            valid_d = 1'b0;
          end else begin
            data_d = step_out;
            idx_d  = idx_q + CNT_W'(1);
          end
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // The datapath is reset as well because hv_data/hv_idx are visible outputs
  // that must read zero while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rule_q  <= RULE90;
      bound_q <= BND_CYCLIC;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rule_q  <= rule_d;
      bound_q <= bound_d;
      valid_q <= valid_d;
    end
  end

  assign cmd_ready = idle;
  assign busy      = !idle;
  assign hv_valid  = valid_q;
  assign hv_data   = data_q;
  assign hv_idx    = idx_q;
  // Gated by valid so a stale count left over in IDLE never raises it.
  assign hv_last   = valid_q && (idx_q == cnt_q - CNT_W'(1));
  assign done      = (state_q == ST_FIN) && !abort;

endmodule
